// File: rtl/csa_pipe_if.sv
// Operand/result bus for csa_pipe: one operand channel and one result channel.
// Both channels transfer on valid & ready at a rising edge; a valid beat is held until taken.
interface csa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready flow control.
// Define CSA_SAT_EN to saturate the result on signed overflow (flags stay raw).
module csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  csa_pipe_if.slave  bus
);
  localparam int NBLK = WIDTH / BLK;

  if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_bad_cfg
    $error("csa_pipe: WIDTH (%0d) must be a non-zero multiple of BLK (%0d)", WIDTH, BLK);
  end

  // Stage 1 state: propagate/generate terms of the effective add
  logic             s1_v_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] g_q;
  logic [NBLK-1:0]  bp_q;
  logic             c0_q;
  logic             x_msb_q;
  logic             yy_msb_q;

  // Stage 2 state: registered result
  logic             s2_v_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;

  logic [WIDTH-1:0] yy_d;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] g_d;
  logic [NBLK-1:0]  bp_d;
  logic             c0_d;

  logic [NBLK:0]    blk_c;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] sum_raw;
  logic             cout_raw;
  logic             ovf_raw;
  logic [WIDTH-1:0] sum_d;

  // A full pipe still accepts when the consumer drains the head in the same edge.
  assign s2_adv       = ~s2_v_q | bus.out_ready;
  assign s1_adv       = ~s1_v_q | s2_adv;
  assign bus.in_ready = rst_n & s1_adv;
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    yy_d = bus.sub ? ~bus.y : bus.y;
    c0_d = bus.sub | bus.cin;
    p_d  = bus.x ^ yy_d;
    g_d  = bus.x & yy_d;
    bp_d = '0;
    for (int k = 0; k < NBLK; k++) begin
      bp_d[k] = &p_d[k*BLK +: BLK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      bp_q     <= '0;
      c0_q     <= 1'b0;
      x_msb_q  <= 1'b0;
      yy_msb_q <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= in_fire;
      if (in_fire) begin
        p_q      <= p_d;
        g_q      <= g_d;
        bp_q     <= bp_d;
        c0_q     <= c0_d;
        x_msb_q  <= bus.x[WIDTH-1];
        yy_msb_q <= yy_d[WIDTH-1];
      end
    end
  end

  // Each block ripples internally; a fully propagating block forwards its carry-in directly.
  always_comb begin
    logic rc;
    blk_c    = '0;
    c_bit    = '0;
    blk_c[0] = c0_q;
    for (int k = 0; k < NBLK; k++) begin
      rc = blk_c[k];
      for (int i = 0; i < BLK; i++) begin
        c_bit[k*BLK + i] = rc;
        rc = g_q[k*BLK + i] | (p_q[k*BLK + i] & rc);
      end
      blk_c[k+1] = bp_q[k] ? blk_c[k] : rc;
    end
  end

  assign sum_raw  = p_q ^ c_bit;
  assign cout_raw = blk_c[NBLK];
  assign ovf_raw  = (x_msb_q == yy_msb_q) & (sum_raw[WIDTH-1] != x_msb_q);

`ifdef CSA_SAT_EN
  always_comb begin
    sum_d = sum_raw;
    if (ovf_raw) begin
      sum_d = x_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_d = sum_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_raw;
        ovf_q  <= ovf_raw;
      end
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule
